prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader that sits directly upstream of the multicycle RV32I core's instruction memory. It accepts a framed byte stream over a valid/ready interface and assembles little-endian 32-bit words. It writes them into instruction memory from word address 0 and holds the core in reset until the image is complete. This replaces testbench back-door preloading with a synthesizable load path.

## Interface
- `ADDR_W`, 10: word-address width of instruction memory; capacity is 2^ADDR_W words.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-low reset (0 = reset).
- `in_valid` input 1: byte-stream valid.
- `in_data` input 8: byte-stream data.
- `in_ready` output 1: loader can accept a byte this cycle.
- `start` input 1: single-cycle pulse that restarts a load from DONE or ERR.
- `mem_we` output 1: instruction-memory write strobe, one cycle per word.
- `mem_addr` output ADDR_W: word address of the write.
- `mem_wdata` output 32: word written.
- `cpu_hold` output 1: active-high reset to the core; 1 while loading.
- `done` output 1: image loaded successfully.
- `err` output 1: frame rejected.

## Operation
- Frame format: LEN_LO, LEN_HI, giving a 16-bit word count N. Then 4·N data bytes, each word least-significant byte first. Then an optional checksum byte (see Configuration).
- A byte transfers on a rising edge with `in_valid`=1 and `in_ready`=1. Gaps in `in_valid` are legal at any point.
- State `LEN0` is entered from reset. It accepts LEN_LO and moves to `LEN1`.
- State `LEN1` accepts LEN_HI and then branches:
  - N > 2^ADDR_W: go to `ERR`.
  - N = 0: go to `CSUM` if the checksum is enabled, otherwise `DONE`.
  - Otherwise: go to `DATA`.
- State `DATA` accepts bytes into a 32-bit shift register. After the 4th byte it moves to `WRITE`.
- State `WRITE`:
  - `in_ready`=0 and `mem_we`=1 for exactly one cycle, with `mem_addr`=word index and `mem_wdata`=the assembled word.
  - The word index then increments.
  - Next state is `DATA` if the written index was below N−1. Otherwise it is `CSUM` if the checksum is enabled, or `DONE` if not.
- State `DONE`: `done`=1. A `start` pulse returns to `LEN0`.
- State `ERR`: `err`=1 and no further writes occur. A `start` pulse returns to `LEN0`.
- `in_ready` is 1 only in `LEN0`, `LEN1`, `DATA` and `CSUM`. It is 0 in `WRITE`, `DONE` and `ERR`, so bytes presented there are not consumed.
- `start` is ignored in every state except `DONE` and `ERR`.
- Taking `start` in `DONE` or `ERR` clears the word index, byte counter and checksum accumulator, and sets `cpu_hold`=1 on the same edge.
- Word-index arithmetic is ADDR_W+1 bits wide, so N = 2^ADDR_W is loadable with no wrap. N is compared at full 16-bit width.

## Timing
- Reset values: state=`LEN0`, `in_ready`=1, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=1, `done`=0, `err`=0.
- Asserting `rst` mid-load aborts immediately: all outputs return to reset values and `cpu_hold`=1. Memory contents already written are left as they are.
- All outputs are registered.
- `mem_we` asserts on the cycle after the edge that accepted the 4th byte of a word.
- Maximum throughput is one word per 5 cycles: 4 accept cycles plus 1 `WRITE` cycle.
- `cpu_hold` falls on the same edge that enters `DONE`. It never falls when entering `ERR`.
- `done` and `err` are mutually exclusive.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - An XOR of all data bytes is accumulated in an 8-bit register.
  - State `CSUM` accepts one trailing byte. If it equals the accumulator the next state is `DONE`; otherwise it is `ERR`.
  - For N=0 the expected checksum byte is 0x00.
- `PROG_LOADER_CHECKSUM_EN` undefined:
  - No accumulator and no `CSUM` state.
  - The final `WRITE` goes straight to `DONE`.
  - A trailing byte is not consumed, because `in_ready`=0 in `DONE`.

## Test plan
- Reset then stream 02 00 13 01 00 01 93 01 A0 0A 2B (checksum enabled) -> `mem_we` pulses at addr 0 with 0x01000113, then at addr 1 with 0x0AA00193; `done`=1, `cpu_hold`=0, `err`=0.
- Same stream with last byte 2C -> both words written; `err`=1, `cpu_hold` remains 1, `done`=0.
- With `ADDR_W`=10, stream 01 04 (N=1025) -> `err`=1 right after LEN_HI; `in_ready`=0; no `mem_we` ever asserts.
- Stream 01 00 6F 00 00 00 with `in_valid` toggled off every other cycle (checksum disabled) -> a single write of 0x0000006F at addr 0; `done`=1; one `mem_we` pulse total.
- Pull `rst` low after 2 data bytes, release, then send a full 1-word frame -> the word lands at addr 0; the earlier partial bytes are discarded.
- From `DONE`, pulse `start`, then send 00 00 (plus 00 if the checksum is enabled) -> `cpu_hold` returns to 1 for the reload and drops when `done`=1; no writes occur.

Source files
------------

// File: rtl/prog_loader.sv
// Boot loader: framed byte stream -> 32-bit words in instruction memory, holding the core in reset until done.
// Optional trailing XOR checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR} state_t;
  localparam state_t LAST_NEXT = CSUM;
`else
  typedef enum logic [2:0] {LEN0, LEN1, DATA, WRITE, DONE, ERR} state_t;
  localparam state_t LAST_NEXT = DONE;
`endif

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t            state_reg, state_next;
  logic [15:0]       len_reg, len_next;
  logic [ADDR_W:0]   idx_reg, idx_next;
  logic [1:0]        bcnt_reg, bcnt_next;
  logic [31:0]       word_reg, word_next;
  logic [16:0]       n_full;
  logic              fire;
  logic              ready_next;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum_reg, csum_next;
`endif

  assign fire = in_valid & in_ready;

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    bcnt_next  = bcnt_reg;
    word_next  = word_reg;
    n_full     = {1'b0, in_data, len_reg[7:0]};
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_next  = csum_reg;
`endif
    case (state_reg)
      LEN0: begin
        if (fire) begin
          len_next[7:0] = in_data;
          state_next    = LEN1;
        end
      end
      LEN1: begin
        if (fire) begin
          len_next[15:8] = in_data;
          if (n_full > MAX_WORDS)   state_next = ERR;
          else if (n_full == 17'd0) state_next = LAST_NEXT;
          else                      state_next = DATA;
        end
      end
      DATA: begin
        if (fire) begin
          // Little-endian: each new byte enters at the top and shifts down.
          word_next = {in_data, word_reg[31:8]};
          bcnt_next = bcnt_reg + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_next = csum_reg ^ in_data;
`endif
          if (bcnt_reg == 2'd3) state_next = WRITE;
        end
      end
      WRITE: begin
        idx_next = idx_reg + 1'b1;
        if ((17'(idx_reg) + 17'd1) < {1'b0, len_reg}) state_next = DATA;
        else                                          state_next = LAST_NEXT;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM: begin
        if (fire) state_next = (in_data == csum_reg) ? DONE : ERR;
      end
`endif
      DONE, ERR: begin
        if (start) begin
          state_next = LEN0;
          idx_next   = '0;
          bcnt_next  = 2'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_next  = 8'd0;
`endif
        end
      end
      default: state_next = LEN0;
    endcase
  end

  always_comb begin
    ready_next = 1'b0;
    case (state_next)
`ifdef PROG_LOADER_CHECKSUM_EN
      LEN0, LEN1, DATA, CSUM: ready_next = 1'b1;
`else
      LEN0, LEN1, DATA:       ready_next = 1'b1;
`endif
      default:                ready_next = 1'b0;
    endcase
  end

  // Outputs are registered from the next-state decode so they change with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= LEN0;
      len_reg   <= 16'd0;
      idx_reg   <= '0;
      bcnt_reg  <= 2'd0;
      word_reg  <= 32'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_reg  <= 8'd0;
`endif
      in_ready  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
      bcnt_reg  <= bcnt_next;
      word_reg  <= word_next;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_reg  <= csum_next;
`endif
      in_ready  <= ready_next;
      mem_we    <= (state_next == WRITE);
      if (state_next == WRITE) begin
        mem_addr  <= idx_next[ADDR_W-1:0];
        mem_wdata <= word_next;
      end
      cpu_hold  <= (state_next != DONE);
      done      <= (state_next == DONE);
      err       <= (state_next == ERR);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frame table plus hand sequences, writes checked via a scoreboard queue.
// Builds with or without PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic              start = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start(start), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct packed {
    logic [7:0]  nb;
    logic [95:0] bytes;   // first byte in the top octet
    logic        gaps;
    logic [1:0]  nw;
    logic [63:0] words;   // word k at [32k +: 32]
    logic        done_e;
    logic        err_e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   we_cnt = 0;
  wr_t  sb[$];
  wr_t  mon_e;
  vec_t vecs[5];
  int   nvec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      we_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %h expected no write", mem_addr, mem_wdata);
      end else begin
        mon_e = sb.pop_front();
        $display("write addr=%0h data=%h (expect %0h %h)", mem_addr, mem_wdata, mon_e.addr, mon_e.data);
        check("write_addr", 32'(mem_addr), 32'(mon_e.addr));
        check("write_data", mem_wdata, mon_e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic gap);
    int t;
    t = 0;
    if (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got in_ready=0 for %0d cycles expected acceptance of %h", t, b);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!(done || err) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL end_timeout: got done=%0b err=%0b expected one of them within 100 cycles", done, err);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_cpu_hold", 32'(cpu_hold), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_err", 32'(err), 32'd0);
    check("start_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    int   w0;
    logic [7:0]  cs;
    logic [31:0] w;

`ifdef PROG_LOADER_CHECKSUM_EN
    vecs[0] = '{nb:8'd11, bytes:96'h0200_1301_0001_9301_A00A_2B00, gaps:1'b0, nw:2'd2,
                words:{32'h0AA00193, 32'h01000113}, done_e:1'b1, err_e:1'b0};
    vecs[1] = '{nb:8'd7, bytes:96'h0100_6F00_0000_6F00_0000_0000, gaps:1'b1, nw:2'd1,
                words:{32'h0, 32'h0000006F}, done_e:1'b1, err_e:1'b0};
    vecs[2] = '{nb:8'd2, bytes:96'h0104_0000_0000_0000_0000_0000, gaps:1'b0, nw:2'd0,
                words:64'h0, done_e:1'b0, err_e:1'b1};
    vecs[3] = '{nb:8'd3, bytes:96'h0000_0000_0000_0000_0000_0000, gaps:1'b0, nw:2'd0,
                words:64'h0, done_e:1'b1, err_e:1'b0};
    vecs[4] = '{nb:8'd11, bytes:96'h0200_1301_0001_9301_A00A_2C00, gaps:1'b0, nw:2'd2,
                words:{32'h0AA00193, 32'h01000113}, done_e:1'b0, err_e:1'b1};
    nvec = 5;
`else
    vecs[0] = '{nb:8'd10, bytes:96'h0200_1301_0001_9301_A00A_0000, gaps:1'b0, nw:2'd2,
                words:{32'h0AA00193, 32'h01000113}, done_e:1'b1, err_e:1'b0};
    vecs[1] = '{nb:8'd6, bytes:96'h0100_6F00_0000_0000_0000_0000, gaps:1'b1, nw:2'd1,
                words:{32'h0, 32'h0000006F}, done_e:1'b1, err_e:1'b0};
    vecs[2] = '{nb:8'd2, bytes:96'h0104_0000_0000_0000_0000_0000, gaps:1'b0, nw:2'd0,
                words:64'h0, done_e:1'b0, err_e:1'b1};
    vecs[3] = '{nb:8'd2, bytes:96'h0000_0000_0000_0000_0000_0000, gaps:1'b0, nw:2'd0,
                words:64'h0, done_e:1'b1, err_e:1'b0};
    vecs[4] = '0;
    nvec = 4;
`endif

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < nvec; i++) begin
      v  = vecs[i];
      w0 = we_cnt;
      for (int k = 0; k < int'(v.nw); k++)
        sb.push_back('{addr: ADDR_W'(k), data: v.words[32*k +: 32]});
      for (int k = 0; k < int'(v.nb); k++)
        send_byte(v.bytes[95-8*k -: 8], v.gaps);
      if (v.err_e && v.nw == 2'd0) check("err_after_len_hi", 32'(err), 32'd1);
      wait_end();
      $display("frame %0d: done=%0b err=%0b cpu_hold=%0b writes=%0d", i, done, err, cpu_hold, we_cnt - w0);
      check("frame_done", 32'(done), 32'(v.done_e));
      check("frame_err", 32'(err), 32'(v.err_e));
      check("frame_cpu_hold", 32'(cpu_hold), 32'(!v.done_e));
      check("frame_in_ready", 32'(in_ready), 32'd0);
      check("frame_writes", 32'(we_cnt - w0), 32'(v.nw));
      check("frame_sb_empty", 32'(sb.size()), 32'd0);
      if (i == 0) begin
        // A byte presented in DONE must be ignored; the next frame depends on it.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(negedge clk);
        check("done_no_accept", 32'(in_ready), 32'd0);
        check("done_held", 32'(done), 32'd1);
        in_valid = 1'b0;
      end
      pulse_start();
    end

    // Reset part-way through a word, then load a clean one-word frame.
    w0 = we_cnt;
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{addr: ADDR_W'(0), data: 32'h44332211});
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h44, 1'b0);
`endif
    wait_end();
    $display("midrst frame: done=%0b writes=%0d", done, we_cnt - w0);
    check("midrst_frame_done", 32'(done), 32'd1);
    check("midrst_writes", 32'(we_cnt - w0), 32'd1);
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);
    pulse_start();

    // Full-capacity image: N = 2^ADDR_W must not wrap or error.
    w0 = we_cnt;
    cs = 8'd0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      w = 32'hC0DE0000 | 32'(i);
      sb.push_back('{addr: ADDR_W'(i), data: w});
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], 1'b0);
        cs = cs ^ w[8*k +: 8];
      end
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(cs, 1'b0);
`endif
    wait_end();
    $display("full frame: done=%0b err=%0b writes=%0d last_addr=%0h", done, err, we_cnt - w0, mem_addr);
    check("full_done", 32'(done), 32'd1);
    check("full_err", 32'(err), 32'd0);
    check("full_writes", 32'(we_cnt - w0), 32'(1 << ADDR_W));
    check("full_last_addr", 32'(mem_addr), 32'((1 << ADDR_W) - 1));
    check("full_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
